// File: rtl/matrix_kb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_kb_pkg
//  Description : Shared definitions for the membrane-matrix to PS/2 set-2
//                encoder: FSM state encoding, event record and key ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_kb_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Scan FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_SAMPLE  = 2'd2;
    localparam logic [1:0] ST_COMPARE = 2'd3;

    // Shift keys: CAPS SHIFT maps to left Shift, SYMBOL SHIFT to right Ctrl
    localparam logic [7:0] CODE_CS = 8'h12;
    localparam logic [7:0] CODE_SS = 8'h14;

    // One queued keyboard event, same shape as the PS/2 receiver output
    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } kb_event_t;

    // Matrix position -> {extended, set-2 code}; case label is octal {row,col}
    function automatic logic [8:0] keycode(input logic [2:0] row, input logic [2:0] col);
        logic [8:0] kc;
        kc = 9'h000;
        case ({row, col})
            6'o00: kc = {1'b0, CODE_CS};
            6'o01: kc = 9'h01A;
            6'o02: kc = 9'h022;
            6'o03: kc = 9'h021;
            6'o04: kc = 9'h02A;
            6'o10: kc = 9'h01C;
            6'o11: kc = 9'h01B;
            6'o12: kc = 9'h023;
            6'o13: kc = 9'h02B;
            6'o14: kc = 9'h034;
            6'o20: kc = 9'h015;
            6'o21: kc = 9'h01D;
            6'o22: kc = 9'h024;
            6'o23: kc = 9'h02D;
            6'o24: kc = 9'h02C;
            6'o30: kc = 9'h016;
            6'o31: kc = 9'h01E;
            6'o32: kc = 9'h026;
            6'o33: kc = 9'h025;
            6'o34: kc = 9'h02E;
            6'o40: kc = 9'h045;
            6'o41: kc = 9'h046;
            6'o42: kc = 9'h03E;
            6'o43: kc = 9'h03D;
            6'o44: kc = 9'h036;
            6'o50: kc = 9'h04D;
            6'o51: kc = 9'h044;
            6'o52: kc = 9'h043;
            6'o53: kc = 9'h03C;
            6'o54: kc = 9'h035;
            6'o60: kc = 9'h05A;
            6'o61: kc = 9'h04B;
            6'o62: kc = 9'h042;
            6'o63: kc = 9'h03B;
            6'o64: kc = 9'h033;
            6'o70: kc = 9'h029;
            6'o71: kc = {1'b1, CODE_SS};
            6'o72: kc = 9'h03A;
            6'o73: kc = 9'h031;
            6'o74: kc = 9'h032;
            default: kc = 9'h000;
        endcase
        return kc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : scan_event_fifo
//  Description : Synchronous FIFO holding pending key events. Pushes while
//                full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset discards any queued entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + 1'b1;
            if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/matrix_to_scancode.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_to_scancode
//  Description : Scans an 8x5 Spectrum membrane matrix, debounces every key
//                and emits paced PS/2 set-2 make/break events.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_to_scancode
    import matrix_kb_pkg::*;
#(
    parameter int SETTLE     = 64,
    parameter int DEBOUNCE   = 3,
    parameter int GAP        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] kb_rows,
    input  logic [4:0] kb_cols,
    output logic       scan_received,
    output logic [7:0] scan,
    output logic       extended,
    output logic       released,
    output logic       overflow
);

    localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

    // Scan FSM
    logic [1:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [4:0]    samp_q, samp_d;
    logic [4:0]    sync1_q, sync2_q;

    // Debounce array: stable level (1 = released) and per-key counter
    logic [NUM_KEYS-1:0] stable_q;
    logic [2:0]          cnt_q [NUM_KEYS];
    logic [2:0]          key_cnt_d;
    logic                key_stable_d;

    // Output pacer
    logic [GW-1:0] gap_q;
    logic          strobe_q;
    logic [7:0]    scan_q;
    logic          ext_q;
    logic          rel_q;
    logic          overflow_q;

    logic [5:0]    w_idx;
    logic          w_in_cmp;
    logic          w_diff;
    logic [2:0]    w_cnt_inc;
    logic          w_reached;
    logic          w_push;
    logic          w_refused;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [8:0]    w_kc;
    kb_event_t     w_push_ev;
    kb_event_t     w_pop_ev;

    assign kb_rows       = (state_q == ST_IDLE) ? 8'hFF : ~(8'd1 << row_q);
    assign scan_received = strobe_q;
    assign scan          = scan_q;
    assign extended      = ext_q;
    assign released      = rel_q;
    assign overflow      = overflow_q;

    // Key under inspection during COMPARE
    assign w_idx     = 6'(row_q) * 6'd5 + 6'(col_q);
    assign w_in_cmp  = (state_q == ST_COMPARE);
    assign w_diff    = (samp_q[col_q] != stable_q[w_idx]);
    assign w_cnt_inc = cnt_q[w_idx] + 3'd1;
    assign w_reached = w_diff && (w_cnt_inc == 3'(DEBOUNCE));
    assign w_push    = w_in_cmp && w_reached && !w_full;
    assign w_refused = w_in_cmp && w_reached && w_full;
    assign w_kc      = keycode(row_q, col_q);
    assign w_push_ev = '{rel: samp_q[col_q], ext: w_kc[8], code: w_kc[7:0]};
    assign w_pop     = !w_empty && (gap_q == '0);

    // Two-flop synchroniser for the asynchronous column sense lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 5'h1F;
            sync2_q <= 5'h1F;
        end else begin
            sync1_q <= kb_cols;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: settle a row, sample it, then walk its five columns
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        settle_d = settle_q;
        samp_d   = samp_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_DRIVE;
                    row_d    = 3'd0;
                    settle_d = '0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SW'(SETTLE - 1)) state_d = ST_SAMPLE;
                else                             settle_d = settle_q + 1'b1;
            end
            ST_SAMPLE: begin
                samp_d  = sync2_q;
                col_d   = 3'd0;
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (col_q == 3'd4) begin
                    row_d    = row_q + 3'd1;
                    settle_d = '0;
                    state_d  = enable ? ST_DRIVE : ST_IDLE;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan FSM registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            settle_q <= '0;
            samp_q   <= 5'h1F;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            settle_q <= settle_d;
            samp_q   <= samp_d;
        end
    end

    // Debounce decision for the current key; a refused push keeps the
    // counter at DEBOUNCE-1 so the event is retried on the next frame
    always_comb begin
        key_cnt_d    = cnt_q[w_idx];
        key_stable_d = stable_q[w_idx];
        if (!w_diff) begin
            key_cnt_d = 3'd0;
        end else if (!w_reached) begin
            key_cnt_d = w_cnt_inc;
        end else if (!w_full) begin
            key_cnt_d    = 3'd0;
            key_stable_d = ~stable_q[w_idx];
        end
    end

    // Debounce array update, one key per COMPARE cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            stable_q <= '1;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= 3'd0;
        end else if (w_in_cmp) begin
            cnt_q[w_idx]    <= key_cnt_d;
            stable_q[w_idx] <= key_stable_d;
        end
    end

    scan_event_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (w_push_ev),
        .pop_i   (w_pop),
        .rdata_o (w_pop_ev),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Output pacer: pop at most once per GAP cycles, sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            gap_q      <= '0;
            strobe_q   <= 1'b0;
            scan_q     <= 8'h00;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q <= w_pop;
            if (w_pop) begin
                scan_q <= w_pop_ev.code;
                ext_q  <= w_pop_ev.ext;
                rel_q  <= w_pop_ev.rel;
                gap_q  <= GW'(GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (w_refused) overflow_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_to_scancode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_to_scancode
//  Description : Directed self-checking bench for matrix_to_scancode with a
//                behavioural membrane matrix driven from a key-state vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_to_scancode;

    localparam int SETTLE     = 8;
    localparam int DEBOUNCE   = 3;
    localparam int GAP        = 1000;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME      = 8 * (SETTLE + 6);

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        int         cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  kb_rows;
    logic [4:0]  kb_cols;
    logic        scan_received;
    logic [7:0]  scan;
    logic        extended;
    logic        released;
    logic        overflow;

    logic [39:0] keys;
    ev_t         evq[$];
    ev_t         mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    matrix_to_scancode #(
        .SETTLE     (SETTLE),
        .DEBOUNCE   (DEBOUNCE),
        .GAP        (GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .kb_rows       (kb_rows),
        .kb_cols       (kb_cols),
        .scan_received (scan_received),
        .scan          (scan),
        .extended      (extended),
        .released      (released),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Membrane model: a pressed key pulls its column low while its row is driven
    always_comb begin
        kb_cols = 5'h1F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!kb_rows[r] && keys[r*5+c]) kb_cols[c] = 1'b0;
    end

    // Event monitor
    always @(negedge clk) begin
        if (scan_received) begin
            mon_e.code = scan;
            mon_e.ext  = extended;
            mon_e.rel  = released;
            mon_e.cyc  = cyc;
            evq.push_back(mon_e);
        end
    end

    task automatic wait_events(input int n, input int budget);
        int k = 0;
        while (evq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Wait for the cycle in which kb_rows starts driving the given pattern
    task automatic align_row(input logic [7:0] pat);
        int k = 0;
        while (kb_rows === pat && k < 2 * FRAME) begin @(negedge clk); k++; end
        while (kb_rows !== pat && k < 4 * FRAME) begin @(negedge clk); k++; end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        enable = 1'b0;
        keys   = '0;
        repeat (4) @(negedge clk);
        checks++; if (kb_rows !== 8'hFF) begin failures++; $display("FAIL reset_kb_rows got=%h exp=ff", kb_rows); end
        checks++; if (scan_received !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", scan_received); end
        checks++; if (scan !== 8'h00) begin failures++; $display("FAIL reset_scan got=%h exp=00", scan); end
        checks++; if (extended !== 1'b0) begin failures++; $display("FAIL reset_ext got=%b exp=0", extended); end
        checks++; if (released !== 1'b0) begin failures++; $display("FAIL reset_rel got=%b exp=0", released); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (kb_rows !== 8'hFF) begin failures++; $display("FAIL idle_kb_rows got=%h exp=ff", kb_rows); end
    endtask

    task automatic test_idle_scan();
        logic [7:0] prev;
        logic [7:0] seen [9];
        logic [7:0] e;
        int n = 0;
        int k = 0;
        prev = 8'hFF;
        evq.delete();
        enable = 1'b1;
        while (n < 9 && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
            if (kb_rows !== prev) begin
                prev = kb_rows;
                seen[n] = kb_rows;
                n++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            e = ~(8'h01 << (i % 8));
            checks++;
            if (n <= i || seen[i] !== e) begin
                failures++;
                $display("FAIL row_seq[%0d] got=%h exp=%h", i, (n <= i) ? 8'hxx : seen[i], e);
            end
        end
        repeat (FRAME) @(negedge clk);
        checks++; if (evq.size() != 0) begin failures++; $display("FAIL idle_events got=%0d exp=0", evq.size()); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_single_key();
        evq.delete();
        keys[15] = 1'b1;
        repeat (5 * FRAME) @(negedge clk);
        keys[15] = 1'b0;
        wait_events(2, 3000);
        repeat (4 * FRAME) @(negedge clk);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL single_count got=%0d exp=2", evq.size());
        end else begin
            checks++; if (evq[0].code !== 8'h16 || evq[0].rel !== 1'b0 || evq[0].ext !== 1'b0) begin
                failures++; $display("FAIL single_make got=%h/e%b/r%b exp=16/e0/r0", evq[0].code, evq[0].ext, evq[0].rel); end
            checks++; if (evq[1].code !== 8'h16 || evq[1].rel !== 1'b1 || evq[1].ext !== 1'b0) begin
                failures++; $display("FAIL single_break got=%h/e%b/r%b exp=16/e0/r1", evq[1].code, evq[1].ext, evq[1].rel); end
        end
    endtask

    task automatic test_glitch();
        evq.delete();
        align_row(8'hFB);
        keys[11] = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        keys[11] = 1'b0;
        repeat (6 * FRAME) @(negedge clk);
        checks++; if (evq.size() != 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", evq.size()); end
    endtask

    task automatic test_simultaneous();
        evq.delete();
        keys[36] = 1'b1;
        keys[37] = 1'b1;
        wait_events(2, 4000);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL simul_make_count got=%0d exp=2", evq.size());
        end else begin
            checks++; if (evq[0].code !== 8'h14 || evq[0].ext !== 1'b1 || evq[0].rel !== 1'b0) begin
                failures++; $display("FAIL simul_ss got=%h/e%b/r%b exp=14/e1/r0", evq[0].code, evq[0].ext, evq[0].rel); end
            checks++; if (evq[1].code !== 8'h3A || evq[1].ext !== 1'b0 || evq[1].rel !== 1'b0) begin
                failures++; $display("FAIL simul_m got=%h/e%b/r%b exp=3a/e0/r0", evq[1].code, evq[1].ext, evq[1].rel); end
            checks++; if (evq[1].cyc - evq[0].cyc < GAP) begin
                failures++; $display("FAIL simul_gap got=%0d exp>=%0d", evq[1].cyc - evq[0].cyc, GAP); end
        end
        keys[36] = 1'b0;
        keys[37] = 1'b0;
        wait_events(4, 4000);
        checks++;
        if (evq.size() != 4) begin
            failures++;
            $display("FAIL simul_break_count got=%0d exp=4", evq.size());
        end else begin
            checks++; if (evq[2].code !== 8'h14 || evq[2].ext !== 1'b1 || evq[2].rel !== 1'b1) begin
                failures++; $display("FAIL simul_ss_break got=%h/e%b/r%b exp=14/e1/r1", evq[2].code, evq[2].ext, evq[2].rel); end
            checks++; if (evq[3].code !== 8'h3A || evq[3].ext !== 1'b0 || evq[3].rel !== 1'b1) begin
                failures++; $display("FAIL simul_m_break got=%h/e%b/r%b exp=3a/e0/r1", evq[3].code, evq[3].ext, evq[3].rel); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [10];
        int nrel;
        exp_codes = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        evq.delete();
        align_row(8'hFE);
        for (int i = 0; i < 10; i++) keys[i] = 1'b1;
        repeat (5 * FRAME) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        wait_events(10, 15000);
        checks++;
        if (evq.size() != 10) begin
            failures++;
            $display("FAIL ovf_make_count got=%0d exp=10", evq.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (evq[i].code !== exp_codes[i] || evq[i].rel !== 1'b0 || evq[i].ext !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_make[%0d] got=%h/e%b/r%b exp=%h/e0/r0", i, evq[i].code, evq[i].ext, evq[i].rel, exp_codes[i]);
                end
            end
        end
        for (int i = 0; i < 10; i++) keys[i] = 1'b0;
        wait_events(20, 15000);
        nrel = 0;
        for (int i = 10; i < evq.size(); i++) if (evq[i].rel === 1'b1) nrel++;
        checks++; if (evq.size() != 20 || nrel != 10) begin
            failures++; $display("FAIL ovf_breaks got=%0d/%0d exp=20/10", evq.size(), nrel); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        evq.delete();
        keys[20] = 1'b1;
        keys[25] = 1'b1;
        wait_events(1, 4000);
        repeat (2 * (SETTLE + 6) + 2) @(negedge clk);
        checks++; if (evq.size() != 1 || evq[0].code !== 8'h45) begin
            failures++; $display("FAIL rmid_first got=%0d events exp=1 with code 45", evq.size()); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (kb_rows !== 8'hFF) begin failures++; $display("FAIL rmid_kb_rows got=%h exp=ff", kb_rows); end
        checks++; if (scan !== 8'h00 || extended !== 1'b0 || released !== 1'b0) begin
            failures++; $display("FAIL rmid_outputs got=%h/e%b/r%b exp=00/e0/r0", scan, extended, released); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
        repeat (3) @(negedge clk);
        evq.delete();
        rst = 1'b1;
        wait_events(2, 4000);
        repeat (4 * FRAME) @(negedge clk);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL rmid_count got=%0d exp=2", evq.size());
        end else begin
            checks++; if (evq[0].code !== 8'h45 || evq[0].rel !== 1'b0) begin
                failures++; $display("FAIL rmid_make0 got=%h/r%b exp=45/r0", evq[0].code, evq[0].rel); end
            checks++; if (evq[1].code !== 8'h4D || evq[1].rel !== 1'b0) begin
                failures++; $display("FAIL rmid_make1 got=%h/r%b exp=4d/r0", evq[1].code, evq[1].rel); end
        end
        keys[20] = 1'b0;
        keys[25] = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        keys   = '0;
        test_reset();
        test_idle_scan();
        test_single_key();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
